// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the serial-SRAM controller.
// Latches the winning command, holds the request until complete, then waits for release.
module mem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_value,
  output logic              mem_write_enable,
  output logic              mem_request,
  input  logic [DATA_W-1:0] mem_read_value,
  input  logic              mem_request_complete,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                mem_request_q, mem_request_d;
  logic                p0_done_q, p0_done_d;
  logic                p1_done_q, p1_done_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_write_value_q, mem_write_value_d;
  logic                mem_write_enable_q, mem_write_enable_d;
  logic                grant_q, grant_d;
  logic                win_valid;
  logic                win_port;

  // With both ports requesting, the port that did not own the last transfer wins.
  always_comb begin
    win_valid = 1'b0;
    win_port  = 1'b0;
    if (p0_req && p1_req) begin
      win_valid = 1'b1;
      win_port  = ~grant_q;
    end else if (p0_req) begin
      win_valid = 1'b1;
      win_port  = 1'b0;
    end else if (p1_req) begin
      win_valid = 1'b1;
      win_port  = 1'b1;
    end else begin
      win_valid = 1'b0;
    end
  end

  // Next-state and datapath updates; everything holds while ena is low.
  always_comb begin
    state_d            = state_q;
    mem_request_d      = mem_request_q;
    p0_done_d          = p0_done_q;
    p1_done_d          = p1_done_q;
    p0_rdata_d         = p0_rdata_q;
    p1_rdata_d         = p1_rdata_q;
    mem_address_d      = mem_address_q;
    mem_write_value_d  = mem_write_value_q;
    mem_write_enable_d = mem_write_enable_q;
    grant_d            = grant_q;
    if (ena) begin
      p0_done_d = 1'b0;
      p1_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          // complete must be low so the previous transfer is fully released
          if (!mem_request_complete && win_valid) begin
            grant_d       = win_port;
            mem_request_d = 1'b1;
            state_d       = BUSY;
            if (win_port) begin
              mem_address_d      = p1_addr;
              mem_write_value_d  = p1_wdata;
              mem_write_enable_d = p1_we;
            end else begin
              mem_address_d      = p0_addr;
              mem_write_value_d  = p0_wdata;
              mem_write_enable_d = p0_we;
            end
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (mem_request_complete) begin
            mem_request_d = 1'b0;
            state_d       = RELEASE;
            if (grant_q) begin
              p1_done_d = 1'b1;
              if (!mem_write_enable_q) p1_rdata_d = mem_read_value;
              else                     p1_rdata_d = p1_rdata_q;
            end else begin
              p0_done_d = 1'b1;
              if (!mem_write_enable_q) p0_rdata_d = mem_read_value;
              else                     p0_rdata_d = p0_rdata_q;
            end
          end else begin
            state_d = BUSY;
          end
        end
        RELEASE: begin
          if (!mem_request_complete) state_d = IDLE;
          else                       state_d = RELEASE;
        end
        default: begin
          state_d       = IDLE;
          mem_request_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset overriding ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      mem_request_q      <= 1'b0;
      p0_done_q          <= 1'b0;
      p1_done_q          <= 1'b0;
      p0_rdata_q         <= '0;
      p1_rdata_q         <= '0;
      mem_address_q      <= '0;
      mem_write_value_q  <= '0;
      mem_write_enable_q <= 1'b0;
      grant_q            <= 1'b1;
    end else begin
      state_q            <= state_d;
      mem_request_q      <= mem_request_d;
      p0_done_q          <= p0_done_d;
      p1_done_q          <= p1_done_d;
      p0_rdata_q         <= p0_rdata_d;
      p1_rdata_q         <= p1_rdata_d;
      mem_address_q      <= mem_address_d;
      mem_write_value_q  <= mem_write_value_d;
      mem_write_enable_q <= mem_write_enable_d;
      grant_q            <= grant_d;
    end
  end

  assign p0_done          = p0_done_q;
  assign p1_done          = p1_done_q;
  assign p0_rdata         = p0_rdata_q;
  assign p1_rdata         = p1_rdata_q;
  assign mem_address      = mem_address_q;
  assign mem_write_value  = mem_write_value_q;
  assign mem_write_enable = mem_write_enable_q;
  assign mem_request      = mem_request_q;
  assign grant            = grant_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single serial-SRAM memory controller between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Sits between the CPU-side ports and the memory controller's request/complete interface.
- Arbitrates round-robin, latches the winning command, and holds the controller request until completion.
- Returns read data with a one-cycle done pulse, then performs the request-release handshake the controller needs before the next transfer.

Parameters:
- ADDR_W, 17, address width; matches the controller address bus.
- DATA_W, 16, word width; matches the controller data bus.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  design enable; low freezes all state.
- p0_req  input  1  port 0 request; held until p0_done.
- p0_we  input  1  port 0 write enable (1 = write).
- p0_addr  input  ADDR_W  port 0 word address.
- p0_wdata  input  DATA_W  port 0 write data.
- p0_rdata  output  DATA_W  port 0 read data; valid when p0_done is high.
- p0_done  output  1  one-cycle completion pulse for port 0.
- p1_req, p1_we, p1_addr, p1_wdata, p1_rdata, p1_done: same as port 0, for port 1.
- mem_address  output  ADDR_W  to controller.
- mem_write_value  output  DATA_W  to controller.
- mem_write_enable  output  1  to controller.
- mem_request  output  1  to controller; level, held for the whole transfer.
- mem_read_value  input  DATA_W  from controller.
- mem_request_complete  input  1  from controller; high until mem_request drops.
- busy  output  1  high whenever state is not IDLE.
- grant  output  1  port owning the current/last transfer (0 or 1).

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous, active-high (rst), and overrides ena.
- Reset values: state = IDLE; mem_request = 0; p0_done = p1_done = 0; p0_rdata = p1_rdata = 0; mem_address = 0; mem_write_value = 0; mem_write_enable = 0; grant = 1, so port 0 wins the first tie; busy = 0.
- ena = 0 and rst = 0: every register holds its value; no state transitions.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - Arbitrates only if mem_request_complete == 0.
  - One requester high: that requester wins.
  - Both requesters high: the port != grant wins (round-robin).
  - On a winner, at the same edge: latch addr/wdata/we into mem_address, mem_write_value and mem_write_enable; set grant; set mem_request = 1; go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - Latched command and mem_request stay constant.
  - Requester inputs are ignored; changes to addr/wdata/we have no effect.
  - On an edge where mem_request_complete == 1:
    - Read: granted port's rdata <= mem_read_value. Write: rdata is unchanged.
    - Granted port's done <= 1.
    - mem_request <= 0.
    - Go to RELEASE.
- RELEASE:
  - done pulses are cleared after exactly one cycle.
  - Stay until mem_request_complete == 0, then go to IDLE.
  - Minimum time is 2 cycles, because the controller clears complete one edge after seeing the request drop.
- Latency:
  - Requester: request sampled in IDLE → mem_request high the next cycle.
  - Controller transfer: 48 controller cycles.
  - Response: done high 1 cycle after complete is seen.
  - Back-to-back: earliest next grant is 3 edges after done rises.
- Requester rule: deassert req on the edge where done is high; a req still high when IDLE samples it is treated as a new request.
- The non-granted port's done and rdata never change.
- Reset mid-transfer:
  - Next cycle: mem_request = 0, state = IDLE.
  - The IDLE guard (complete == 0) prevents issuing a new request before the controller has released.
  - No done pulse is issued for the aborted transfer.
- Simultaneous events:
  - A new request arriving during BUSY or RELEASE waits; it is not lost if held.
  - complete going high on the same edge ena is low is ignored until ena returns high.

Test Plan:
- Single read, port 0, addr 0x00010, SRAM word 0xBEEF → mem_request high one cycle after req; p0_done a 1-cycle pulse; p0_rdata = 0xBEEF; p1_done stays 0.
- Write then read, port 1: write 0x1234 to 0x1FFFF, then read 0x1FFFF → mem_write_enable = 1 during the write; read returns p1_rdata = 0x1234; p0_rdata unchanged.
- Both ports request in the same cycle after reset, held continuously → order 0, 1, 0, 1; grant alternates; each done pulse matches grant; no mem_request rises while complete is high.
- Port 0 changes p0_addr mid-BUSY → mem_address holds the originally latched value until RELEASE.
- rst pulsed 10 cycles into a transfer → mem_request low next cycle; busy = 0; no done pulse; a new p1 read after reset is issued only once complete == 0 and returns correct data.
- ena low for 5 cycles mid-BUSY → all outputs frozen; transfer completes normally after ena returns; done pulse still exactly 1 cycle.
